// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Holds the FSM state encoding, error codes and the default start-of-frame byte.
package uart_frame_parser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Modulo-256 running checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload buffer: MAX_LEN x 8 RAM, one write port, registered read port.
// Only the read register is reset; the array contents are undefined after reset.
module frame_buf
  import uart_frame_parser_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'd0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles bytes from the UART receiver into SOF/LEN/payload/CSUM frames,
// validates them and stores the payload; a gap timeout drops stalled frames.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         UART_BPS = 9600,
  parameter int         MAX_LEN  = 16,
  parameter logic [7:0] SOF      = SOF_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 pi_data,
  input  logic                       pi_flag,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 frame_len,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int AW          = $clog2(MAX_LEN);
  localparam int TIMEOUT_CYC = int'((64'(20) * 64'(CLK_FREQ)) / 64'(UART_BPS));
  localparam int GAP_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_TERM  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_t           state, state_nxt;
  logic [7:0]       len, len_nxt;
  logic [7:0]       sum, sum_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [GAP_W-1:0] gap;
  logic             tout;
  logic             we;
  logic             done_nxt, err_nxt;
  logic [1:0]       code_nxt;
  logic [7:0]       flen_nxt;

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    flen_nxt  = frame_len;
    we        = 1'b0;
    tout      = 1'b0;
    if (pi_flag) begin
      // A byte on the terminal gap cycle takes priority over the timeout.
      unique case (state)
        ST_IDLE: begin
          if (pi_data == SOF) state_nxt = ST_LEN;
        end
        ST_LEN: begin
          if (pi_data == 8'd0 || pi_data > MAX_LEN_B) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
            code_nxt  = ERR_LEN;
          end else begin
            len_nxt   = pi_data;
            sum_nxt   = pi_data;
            cnt_nxt   = 8'd0;
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          we      = 1'b1;
          sum_nxt = csum_add(sum, pi_data);
          cnt_nxt = cnt + 8'd1;
          if (cnt == len - 8'd1) state_nxt = ST_CSUM;
        end
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          if (pi_data == sum) begin
            done_nxt = 1'b1;
            flen_nxt = len;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = ERR_CSUM;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && gap == GAP_TERM) begin
      tout      = 1'b1;
      state_nxt = ST_IDLE;
      err_nxt   = 1'b1;
      code_nxt  = ERR_TOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gap        <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_NONE;
      frame_len  <= 8'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap        <= (pi_flag || tout || state == ST_IDLE) ? '0 : gap + 1'b1;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      err_code   <= code_nxt;
      frame_len  <= flen_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Datapath registers carry no reset; they are always reloaded in LEN before use.
  always_ff @(posedge clk) begin
    len <= len_nxt;
    sum <= sum_nxt;
    cnt <= cnt_nxt;
  end

  frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (pi_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule
